// File: rtl/nv_nvdla_soft_reset_ctl.sv
// nv_nvdla_soft_reset_ctl: software-triggered core reset sequencer with drain, min-width assert and ack handshake
module nv_nvdla_soft_reset_ctl #(
    parameter int NUM_ENG       = 4,
    parameter int CNT_W         = 16,
    parameter int RST_CYCLES    = 16,
    parameter int DRAIN_TIMEOUT = 1024,
    parameter int ACK_TIMEOUT   = 64
) (
    input  logic               nvdla_clk,
    input  logic               dla_reset_rstn,
    input  logic               soft_reset_req,
    input  logic [NUM_ENG-1:0] engine_idle,
    input  logic               synced_rstn,
    output logic               core_reset_rstn,
    output logic               drain_req,
    output logic               soft_reset_busy,
    output logic               soft_reset_done,
    output logic               drain_timeout_err,
    output logic               ack_timeout_err
);
    typedef enum logic [2:0] {IDLE, DRAIN, ASSERT, ACK_LO, RELEASE, ACK_HI, DONE} state_t;

    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] ACK_LAST   = CNT_W'(ACK_TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             all_idle;

    assign all_idle = &engine_idle;
    assign cnt_inc  = (&cnt) ? cnt : cnt + 1'b1;

    // Sequencer: every output is a flop updated on the transition that enters its state
    always_ff @(posedge nvdla_clk or negedge dla_reset_rstn) begin
        if (!dla_reset_rstn) begin
            state             <= IDLE;
            cnt               <= '0;
            core_reset_rstn   <= 1'b1;
            drain_req         <= 1'b0;
            soft_reset_busy   <= 1'b0;
            soft_reset_done   <= 1'b0;
            drain_timeout_err <= 1'b0;
            ack_timeout_err   <= 1'b0;
        end else begin
            soft_reset_done <= 1'b0;
            cnt             <= (state == IDLE) ? '0 : cnt_inc;
            case (state)
                IDLE: if (soft_reset_req) begin
                    state             <= DRAIN;
                    cnt               <= '0;
                    drain_req         <= 1'b1;
                    soft_reset_busy   <= 1'b1;
                    drain_timeout_err <= 1'b0;
                    ack_timeout_err   <= 1'b0;
                end
                DRAIN: if (all_idle || cnt == DRAIN_LAST) begin
                    state           <= ASSERT;
                    cnt             <= '0;
                    core_reset_rstn <= 1'b0;
                    if (!all_idle) drain_timeout_err <= 1'b1;
                end
                ASSERT: if (cnt == RST_LAST) begin
                    state <= ACK_LO;
                    cnt   <= '0;
                end
                ACK_LO: if (!synced_rstn || cnt == ACK_LAST) begin
                    state           <= RELEASE;
                    cnt             <= '0;
                    core_reset_rstn <= 1'b1;
                    drain_req       <= 1'b0;
                    if (synced_rstn) ack_timeout_err <= 1'b1;
                end
                RELEASE: begin
                    state <= ACK_HI;
                    cnt   <= '0;
                end
                ACK_HI: if (synced_rstn || cnt == ACK_LAST) begin
                    state           <= DONE;
                    cnt             <= '0;
                    soft_reset_done <= 1'b1;
                    if (!synced_rstn) ack_timeout_err <= 1'b1;
                end
                DONE: begin
                    state           <= IDLE;
                    cnt             <= '0;
                    soft_reset_busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
